// File: rtl/instr_split_stage.sv
`default_nettype none
// ============================================================================
// Module   : instr_split_stage
// Brief    : Registered IF->ID stage with a 2-entry skid buffer; splits a MIPS
//            instruction word into its fields and precomputes pc_plus4.
// Revision : 1.0 - initial release
// ============================================================================
module instr_split_stage #(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            flush,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [XLEN-1:0] in_instr,
    input  logic [XLEN-1:0] in_pc,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [5:0]      op,
    output logic [4:0]      rs,
    output logic [4:0]      rt,
    output logic [4:0]      rd,
    output logic [4:0]      shamt,
    output logic [5:0]      funct,
    output logic [15:0]     imm16,
    output logic [XLEN-1:0] imm_sext,
    output logic [25:0]     target26,
    output logic [XLEN-1:0] pc_plus4,
    output logic [3:0]      pc_hi4,
    output logic [XLEN-1:0] instr_out
);

    localparam logic [XLEN-1:0] c_PC_INC = 4;

    logic            r_m_valid;
    logic [XLEN-1:0] r_m_instr;
    logic [XLEN-1:0] r_m_pc4;
    logic            r_s_valid;
    logic [XLEN-1:0] r_s_instr;
    logic [XLEN-1:0] r_s_pc4;
    logic            r_in_ready;

    logic            w_in_fire;
    logic            w_out_fire;
    logic [XLEN-1:0] w_in_pc4;
    logic            w_m_valid_nxt;
    logic            w_s_valid_nxt;
    logic            w_m_load_in;
    logic            w_m_load_s;
    logic            w_s_load;

    assign w_in_fire  = in_valid & r_in_ready;
    assign w_out_fire = r_m_valid & out_ready;
    assign w_in_pc4   = in_pc + c_PC_INC;

    // M always holds the oldest entry; S only fills while M is stalled.
    always_comb begin
        w_m_valid_nxt = r_m_valid;
        w_s_valid_nxt = r_s_valid;
        w_m_load_in   = 1'b0;
        w_m_load_s    = 1'b0;
        w_s_load      = 1'b0;
        if (flush) begin
            w_m_valid_nxt = 1'b0;
            w_s_valid_nxt = 1'b0;
        end else if (w_out_fire) begin
            if (r_s_valid) begin
                w_m_load_s    = 1'b1;
                w_s_valid_nxt = 1'b0;
            end else if (w_in_fire) begin
                w_m_load_in   = 1'b1;
            end else begin
                w_m_valid_nxt = 1'b0;
            end
        end else if (w_in_fire) begin
            if (r_m_valid) begin
                w_s_load      = 1'b1;
                w_s_valid_nxt = 1'b1;
            end else begin
                w_m_load_in   = 1'b1;
                w_m_valid_nxt = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_m_valid  <= 1'b0;
            r_m_instr  <= '0;
            r_m_pc4    <= '0;
            r_s_valid  <= 1'b0;
            r_s_instr  <= '0;
            r_s_pc4    <= '0;
            r_in_ready <= 1'b1;
        end else begin
            r_m_valid  <= w_m_valid_nxt;
            r_s_valid  <= w_s_valid_nxt;
            r_in_ready <= ~w_s_valid_nxt;
            if (w_m_load_in) begin
                r_m_instr <= in_instr;
                r_m_pc4   <= w_in_pc4;
            end else if (w_m_load_s) begin
                r_m_instr <= r_s_instr;
                r_m_pc4   <= r_s_pc4;
            end
            if (w_s_load) begin
                r_s_instr <= in_instr;
                r_s_pc4   <= w_in_pc4;
            end
        end
    end

    assign in_ready  = r_in_ready;
    assign out_valid = r_m_valid;
    assign op        = r_m_instr[31:26];
    assign rs        = r_m_instr[25:21];
    assign rt        = r_m_instr[20:16];
    assign rd        = r_m_instr[15:11];
    assign shamt     = r_m_instr[10:6];
    assign funct     = r_m_instr[5:0];
    assign imm16     = r_m_instr[15:0];
    assign imm_sext  = {{(XLEN-16){r_m_instr[15]}}, r_m_instr[15:0]};
    assign target26  = r_m_instr[25:0];
    assign pc_plus4  = r_m_pc4;
    assign pc_hi4    = r_m_pc4[XLEN-1:XLEN-4];
    assign instr_out = r_m_instr;

endmodule
`default_nettype wire

// File: tb/tb_instr_split_stage.sv
`default_nettype none
// ============================================================================
// Module   : tb_instr_split_stage
// Brief    : Self-checking bench for instr_split_stage: directed scenarios plus
//            a randomized run against a depth-2 FIFO reference model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_instr_split_stage;

    logic        clk = 1'b0;
    logic        rst;
    logic        flush;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_instr;
    logic [31:0] in_pc;
    logic        out_valid;
    logic        out_ready;
    logic [5:0]  op;
    logic [4:0]  rs;
    logic [4:0]  rt;
    logic [4:0]  rd;
    logic [4:0]  shamt;
    logic [5:0]  funct;
    logic [15:0] imm16;
    logic [31:0] imm_sext;
    logic [25:0] target26;
    logic [31:0] pc_plus4;
    logic [3:0]  pc_hi4;
    logic [31:0] instr_out;

    int vectors = 0;
    int errors  = 0;

    typedef struct packed {
        logic [31:0] instr;
        logic [31:0] pc;
    } ent_t;

    always #5 clk = ~clk;

    instr_split_stage #(.XLEN(32)) dut (
        .clk       (clk),
        .rst       (rst),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_instr  (in_instr),
        .in_pc     (in_pc),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .op        (op),
        .rs        (rs),
        .rt        (rt),
        .rd        (rd),
        .shamt     (shamt),
        .funct     (funct),
        .imm16     (imm16),
        .imm_sext  (imm_sext),
        .target26  (target26),
        .pc_plus4  (pc_plus4),
        .pc_hi4    (pc_hi4),
        .instr_out (instr_out)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        in_instr = 32'hDEADBEEF; in_pc = 32'h1234_5678;
        tick();
        tick();
        vectors++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got %0b want 0", out_valid); end
        vectors++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready got %0b want 1", in_ready); end
        vectors++; if (op !== 6'd0) begin errors++; $display("FAIL reset_op got %h want 0", op); end
        vectors++; if (pc_plus4 !== 32'd0) begin errors++; $display("FAIL reset_pc_plus4 got %h want 0", pc_plus4); end
        vectors++; if (instr_out !== 32'd0) begin errors++; $display("FAIL reset_instr_out got %h want 0", instr_out); end
        rst = 1'b0;
        tick();
    endtask

    task automatic test_rtype();
        out_ready = 1'b1; in_valid = 1'b1;
        in_instr = 32'h00851021; in_pc = 32'h00400010;
        tick();
        in_valid = 1'b0;
        vectors++; if (out_valid !== 1'b1) begin errors++; $display("FAIL rtype_valid got %0b want 1", out_valid); end
        vectors++; if ({op, rs, rt, rd, shamt, funct} !== {6'h00, 5'd4, 5'd5, 5'd2, 5'd0, 6'h21})
            begin errors++; $display("FAIL rtype_fields got op=%h rs=%0d rt=%0d rd=%0d sh=%0d fn=%h want 00/4/5/2/0/21", op, rs, rt, rd, shamt, funct); end
        vectors++; if (pc_plus4 !== 32'h00400014) begin errors++; $display("FAIL rtype_pc_plus4 got %h want 00400014", pc_plus4); end
        tick();
        vectors++; if (out_valid !== 1'b0) begin errors++; $display("FAIL rtype_drain got %0b want 0", out_valid); end
    endtask

    task automatic test_itype_jtype();
        out_ready = 1'b1; in_valid = 1'b1;
        in_instr = 32'h2042FFFF; in_pc = 32'h00000100;
        tick();
        vectors++; if (op !== 6'h08 || imm16 !== 16'hFFFF || imm_sext !== 32'hFFFFFFFF)
            begin errors++; $display("FAIL itype got op=%h imm16=%h sext=%h want 08 FFFF FFFFFFFF", op, imm16, imm_sext); end
        in_instr = 32'h08100004; in_pc = 32'h7FFFFFFC;
        tick();
        in_valid = 1'b0;
        vectors++; if (out_valid !== 1'b1 || op !== 6'h02 || target26 !== 26'h0100004)
            begin errors++; $display("FAIL jtype got v=%0b op=%h t26=%h want 1 02 0100004", out_valid, op, target26); end
        vectors++; if (pc_plus4 !== 32'h80000000 || pc_hi4 !== 4'h8)
            begin errors++; $display("FAIL jtype_pc got %h hi=%h want 80000000 8", pc_plus4, pc_hi4); end
        tick();
    endtask

    task automatic test_backpressure();
        out_ready = 1'b0; in_valid = 1'b1;
        in_instr = 32'hAAAA0001; in_pc = 32'h1000;
        tick();
        vectors++; if (instr_out !== 32'hAAAA0001 || in_ready !== 1'b1)
            begin errors++; $display("FAIL bp_a got %h rdy=%0b want AAAA0001 1", instr_out, in_ready); end
        in_instr = 32'hBBBB0002; in_pc = 32'h1004;
        tick();
        vectors++; if (instr_out !== 32'hAAAA0001 || in_ready !== 1'b0)
            begin errors++; $display("FAIL bp_b got %h rdy=%0b want AAAA0001 0", instr_out, in_ready); end
        in_instr = 32'hCCCC0003; in_pc = 32'h1008;
        tick();
        vectors++; if (instr_out !== 32'hAAAA0001 || in_ready !== 1'b0 || out_valid !== 1'b1)
            begin errors++; $display("FAIL bp_c_held got %h rdy=%0b v=%0b want AAAA0001 0 1", instr_out, in_ready, out_valid); end
        out_ready = 1'b1;
        tick();
        vectors++; if (instr_out !== 32'hBBBB0002 || pc_plus4 !== 32'h1008 || in_ready !== 1'b1)
            begin errors++; $display("FAIL bp_out_b got %h pc4=%h rdy=%0b want BBBB0002 1008 1", instr_out, pc_plus4, in_ready); end
        tick();
        in_valid = 1'b0;
        vectors++; if (instr_out !== 32'hCCCC0003 || out_valid !== 1'b1 || pc_plus4 !== 32'h100C)
            begin errors++; $display("FAIL bp_out_c got %h v=%0b pc4=%h want CCCC0003 1 100C", instr_out, out_valid, pc_plus4); end
        tick();
        vectors++; if (out_valid !== 1'b0) begin errors++; $display("FAIL bp_empty got %0b want 0", out_valid); end
    endtask

    task automatic test_flush();
        out_ready = 1'b0; in_valid = 1'b1;
        in_instr = 32'h11110001; tick();
        in_instr = 32'h22220002; tick();
        flush = 1'b1; in_instr = 32'hDDDD0004;
        tick();
        flush = 1'b0; in_valid = 1'b0;
        vectors++; if (out_valid !== 1'b0 || in_ready !== 1'b1)
            begin errors++; $display("FAIL flush_full got v=%0b rdy=%0b want 0 1", out_valid, in_ready); end
        // Only M held: the flush-cycle input would otherwise be accepted.
        in_valid = 1'b1; in_instr = 32'h33330003; tick();
        flush = 1'b1; in_instr = 32'hDDDD0004; tick();
        flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        tick();
        vectors++; if (out_valid !== 1'b0 || in_ready !== 1'b1)
            begin errors++; $display("FAIL flush_d_seen got v=%0b rdy=%0b instr=%h want 0 1", out_valid, in_ready, instr_out); end
    endtask

    task automatic test_wrap();
        out_ready = 1'b1; in_valid = 1'b1;
        in_instr = 32'h0000000C; in_pc = 32'hFFFFFFFC;
        tick();
        in_valid = 1'b0;
        vectors++; if (out_valid !== 1'b1 || pc_plus4 !== 32'h0 || pc_hi4 !== 4'h0)
            begin errors++; $display("FAIL wrap got v=%0b pc4=%h hi=%h want 1 00000000 0", out_valid, pc_plus4, pc_hi4); end
        tick();
    endtask

    task automatic test_random();
        ent_t        q[$];
        ent_t        e;
        int          accepted = 0;
        int          cycles   = 0;
        logic        exp_rdy;
        logic        in_fire;
        logic        out_fire;
        logic [31:0] w;
        logic [31:0] p4;
        flush = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
        tick();
        flush = 1'b0;
        while (accepted < 1000 && cycles < 20000) begin
            exp_rdy = (q.size() < 2);
            vectors++; if (in_ready !== exp_rdy) begin errors++; $display("FAIL rnd_in_ready cyc=%0d got %0b want %0b", cycles, in_ready, exp_rdy); end
            vectors++; if (out_valid !== (q.size() > 0)) begin errors++; $display("FAIL rnd_out_valid cyc=%0d got %0b want %0b", cycles, out_valid, q.size() > 0); end
            if (q.size() > 0) begin
                w  = q[0].instr;
                p4 = q[0].pc + 32'd4;
                vectors++; if (instr_out !== w || pc_plus4 !== p4 || pc_hi4 !== 4'(p4 / 32'h1000_0000))
                    begin errors++; $display("FAIL rnd_word cyc=%0d got %h pc4=%h hi=%h want %h %h", cycles, instr_out, pc_plus4, pc_hi4, w, p4); end
                vectors++; if (op !== 6'(w / (1 << 26)) || rs !== 5'((w / (1 << 21)) % 32) || rt !== 5'((w / (1 << 16)) % 32) ||
                               rd !== 5'((w / (1 << 11)) % 32) || shamt !== 5'((w / (1 << 6)) % 32) || funct !== 6'(w % 64))
                    begin errors++; $display("FAIL rnd_fields cyc=%0d word=%h got op=%h rs=%0d rt=%0d rd=%0d sh=%0d fn=%h", cycles, w, op, rs, rt, rd, shamt, funct); end
                vectors++; if (imm16 !== 16'(w % 65536) || target26 !== 26'(w % (1 << 26)) ||
                               imm_sext !== ((w % 65536 >= 32768) ? (w % 65536) + 32'hFFFF0000 : w % 65536))
                    begin errors++; $display("FAIL rnd_imm cyc=%0d word=%h got imm=%h sext=%h t26=%h", cycles, w, imm16, imm_sext, target26); end
            end
            in_valid  = ($urandom_range(0, 9) < 7);
            out_ready = ($urandom_range(0, 9) < 6);
            flush     = ($urandom_range(0, 99) < 2);
            in_instr  = $urandom;
            in_pc     = ($urandom_range(0, 15) == 0) ? 32'hFFFFFFFC : ($urandom & 32'hFFFFFFFC);
            in_fire   = in_valid && exp_rdy;
            out_fire  = out_ready && (q.size() > 0);
            if (out_fire) void'(q.pop_front());
            if (flush) q.delete();
            else if (in_fire) begin
                e.instr = in_instr; e.pc = in_pc;
                q.push_back(e);
            end
            if (in_fire) accepted++;
            tick();
            cycles++;
        end
        flush = 1'b0; in_valid = 1'b0;
        vectors++; if (accepted < 1000) begin errors++; $display("FAIL rnd_budget accepted %0d want 1000", accepted); end
    endtask

    initial begin
        test_reset();
        test_rtype();
        test_itype_jtype();
        test_backpressure();
        test_flush();
        test_wrap();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end

endmodule
`default_nettype wire
